// File: rtl/latch_vs_flop_pkg.sv
// Shared constants and helpers for the latch-vs-flop reference cell.
//   LVF_WIDTH  : default data width of d / q_latch / q_flop
//   LVF_CNT_W  : default width of the saturating mismatch counter
//   sat_inc()  : increment that sticks at max_val instead of wrapping
package latch_vs_flop_pkg;

  localparam int unsigned LVF_WIDTH = 1;
  localparam int unsigned LVF_CNT_W = 8;

  // Saturating increment on a 32-bit carrier; callers cast to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/lvf_mismatch_counter.sv
// Mismatch detector plus saturating mismatch counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   q_latch        : latch output
//   q_flop         : flop output (current)
//   q_flop_nxt     : value the flop holds once the current edge has settled
//   mismatch       : combinational, any bit of q_latch differs from q_flop
//   mismatch_cnt   : count of edges after which the two elements disagree
//   cnt_sat        : mismatch_cnt is all-ones
module lvf_mismatch_counter
  import latch_vs_flop_pkg::*;
#(
  parameter int unsigned WIDTH = LVF_WIDTH,
  parameter int unsigned CNT_W = LVF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q_latch,
  input  logic [WIDTH-1:0] q_flop,
  input  logic [WIDTH-1:0] q_flop_nxt,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic edge_mismatch_c;

  // Observable disagreement between the two storage elements.
  assign mismatch = |(q_latch ^ q_flop);

  // An edge counts only if the elements still disagree after the flop has
  // taken that edge; the transient window while the latch runs ahead of the
  // flop (en=1, d changed between edges) is therefore never counted.
  assign edge_mismatch_c = |(q_latch ^ q_flop_nxt);

  // Saturating counter: never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (edge_mismatch_c) begin
      mismatch_cnt <= CNT_W'(sat_inc(32'(mismatch_cnt), 32'(CNT_MAX)));
    end
  end

  assign cnt_sat = (mismatch_cnt == CNT_MAX);

endmodule

// File: rtl/latch_vs_flop_unit.sv
// Side-by-side level-sensitive latch and edge-triggered flop on shared d/en,
// with a detector counting clock edges where the two disagree.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset (clears latch, flop, counter)
//   en            : latch gate / flop load enable
//   d             : shared data input
//   q_latch       : latch output (transparent while en=1)
//   q_flop        : flop output (loads d on rising clk when en=1)
//   mismatch      : combinational q_latch != q_flop
//   mismatch_cnt  : saturating count of mismatching edges
//   cnt_sat       : mismatch_cnt at all-ones
module latch_vs_flop_unit
  import latch_vs_flop_pkg::*;
#(
  parameter int unsigned WIDTH = LVF_WIDTH,
  parameter int unsigned CNT_W = LVF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_latch,
  output logic [WIDTH-1:0] q_flop,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             cnt_sat
);

  logic [WIDTH-1:0] q_flop_nxt;

  // Intentional level-sensitive latch: follows d while en=1, holds otherwise.
  always_latch begin
    if (!rst_n) begin
      q_latch = '0;
    end else if (en) begin
      q_latch = d;
    end
  end

  // Flop load-enable mux; also tells the detector where the flop is heading.
  assign q_flop_nxt = en ? d : q_flop;

  // Edge-triggered flop with load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flop <= '0;
    end else begin
      q_flop <= q_flop_nxt;
    end
  end

  lvf_mismatch_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mismatch_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .q_latch      (q_latch),
    .q_flop       (q_flop),
    .q_flop_nxt   (q_flop_nxt),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt),
    .cnt_sat      (cnt_sat)
  );

endmodule

// File: tb/tb_latch_vs_flop_unit.sv
// Directed bench for latch_vs_flop_unit (WIDTH=1, CNT_W=8, clk period 10, first rise at 5).
module tb_latch_vs_flop_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [0:0] d;
  logic [0:0] q_latch;
  logic [0:0] q_flop;
  logic       mismatch;
  logic [7:0] mismatch_cnt;
  logic       cnt_sat;

  int tests_run;
  int tests_failed;

  latch_vs_flop_unit #(
    .WIDTH (1),
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .d            (d),
    .q_latch      (q_latch),
    .q_flop       (q_flop),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt),
    .cnt_sat      (cnt_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Checks all five outputs in one go.
  task automatic chk_all(input string tag, input logic ql, input logic qf,
                         input logic mm, input logic [7:0] cnt, input logic sat);
    chk({tag, ".q_latch"},  32'(q_latch),      32'(ql));
    chk({tag, ".q_flop"},   32'(q_flop),       32'(qf));
    chk({tag, ".mismatch"}, 32'(mismatch),     32'(mm));
    chk({tag, ".cnt"},      32'(mismatch_cnt), 32'(cnt));
    chk({tag, ".cnt_sat"},  32'(cnt_sat),      32'(sat));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // 1. Reset held with d=1, en=1 while clk toggles.
    rst_n = 1'b0;
    d     = 1'b1;
    en    = 1'b1;
    at(3);  chk_all("rst_pre_edge",  1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    at(7);  chk_all("rst_post_edge", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    d = 1'b0;
    at(8);  rst_n = 1'b1;
    at(9);  chk_all("rst_release", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // 2. d rises at 10: latch follows at once, flop at edge 15, no count.
    at(10); d = 1'b1;
    at(11); chk_all("d1_latch_first", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    at(16); chk_all("d1_flop_caught", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // 3. d falls at 20.
    at(20); d = 1'b0;
    at(21); chk_all("d0_latch_first", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    at(26); chk_all("d0_flop_caught", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // 4. en low at 30, d=1 at 40: both hold through 60.
    at(30); en = 1'b0;
    at(40); d = 1'b1;
    at(41); chk_all("hold_41", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    at(50); chk_all("hold_50", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    at(59); chk_all("hold_59", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // 5. en=1 with d rising mid-cycle at 62.
    at(58); d = 1'b0;
    at(60); en = 1'b1;
    at(62); d = 1'b1;
    at(63); chk_all("mid_latch", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    at(66); chk_all("mid_flop",  1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Latch drops to 0; then en falls with a coincident d change: 0 is held.
    at(67); d = 1'b0;
    at(68); chk("pre_fall.q_latch", 32'(q_latch), 32'd0);
    at(69); en = 1'b0; d = 1'b1;
    at(70); chk_all("en_fall_hold", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);

    // 6. Persistent mismatch: every edge from 75 on counts.
    at(76);   chk_all("cnt_first",  1'b0, 1'b1, 1'b1, 8'd1,   1'b0);
    at(86);   chk("cnt_second", 32'(mismatch_cnt), 32'd2);
    at(2606); chk_all("cnt_254",    1'b0, 1'b1, 1'b1, 8'd254, 1'b0);
    at(2616); chk_all("cnt_255",    1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
    at(3076); chk_all("cnt_300",    1'b0, 1'b1, 1'b1, 8'd255, 1'b1);

    // Mid-cycle reset pulse clears everything immediately.
    at(3078); rst_n = 1'b0; en = 1'b1; d = 1'b1;
    at(3079); chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Release with en=1, d=1: latch follows immediately, flop on next edge.
    at(3080); rst_n = 1'b1;
    at(3081); chk_all("post_rst_latch", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    at(3086); chk_all("post_rst_flop",  1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
